// File: rtl/mul_share_arbiter_if.sv
// Requester-side bundle for mul_share_arbiter: packed request and response
// handshakes, requester i at [i*DATA_LEN +: DATA_LEN].
interface mul_share_arbiter_if #(
   parameter int NUM_REQ  = 4,
   parameter int DATA_LEN = 32
);
   logic [NUM_REQ-1:0]          req_valid;
   logic [NUM_REQ-1:0]          req_ready;
   logic [NUM_REQ*DATA_LEN-1:0] req_a;
   logic [NUM_REQ*DATA_LEN-1:0] req_b;
   logic [NUM_REQ-1:0]          rsp_valid;
   logic [NUM_REQ-1:0]          rsp_ready;
   logic [NUM_REQ*DATA_LEN-1:0] rsp_result;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_result
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_result
   );
endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one fixed-latency pipelined multiplier between NUM_REQ
// requesters; a tag pipe follows each op so its product returns to its owner.
module mul_share_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int DATA_LEN    = 32,
   parameter int MUL_LATENCY = 2
) (
   input  logic                clk,
   input  logic                reset_n,
   mul_share_arbiter_if.slave  bus,
   input  logic                flush,
   output logic                mul_reset,
   output logic [DATA_LEN-1:0] mul_a,
   output logic [DATA_LEN-1:0] mul_b,
   input  logic [DATA_LEN-1:0] mul_result,
   output logic                busy,
   output logic [31:0]         issue_count
);
   localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int DEPTH = MUL_LATENCY + 1;

   typedef logic [ID_W-1:0] id_t;
   typedef logic [ID_W:0]   idx_t;
   typedef struct packed {
      logic valid;
      id_t  id;
   } tag_t;

   tag_t                tag_pipe [DEPTH];
   logic [DATA_LEN-1:0] rsp_data [NUM_REQ];
   logic [NUM_REQ-1:0]  inflight;
   logic [NUM_REQ-1:0]  rsp_valid_q;
   logic [NUM_REQ-1:0]  eligible;
   logic [NUM_REQ-1:0]  grant;
   id_t                 rr_ptr;
   id_t                 grant_id;
   id_t                 next_ptr;
   idx_t                idx;
   logic                issue;
   logic                deliver;
   tag_t                exit_tag;
   logic [DATA_LEN-1:0] sel_a;
   logic [DATA_LEN-1:0] sel_b;

   // One op outstanding per requester, so a returning product always has a free slot.
   assign eligible = bus.req_valid & ~inflight & ~rsp_valid_q & {NUM_REQ{~flush}};

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      issue    = 1'b0;
      grant_id = '0;
      idx      = '0;
      // Walking the offsets downwards lets the closest eligible requester win.
      for (int off = NUM_REQ - 1; off >= 0; off--) begin
         idx = {1'b0, rr_ptr} + idx_t'(off);
         if (idx >= idx_t'(NUM_REQ)) begin
            idx = idx - idx_t'(NUM_REQ);
         end
         if (eligible[idx[ID_W-1:0]]) begin
            issue    = 1'b1;
            grant_id = idx[ID_W-1:0];
         end
      end
      grant = '0;
      if (issue) begin
         grant[grant_id] = 1'b1;
      end
   end

   assign next_ptr = (grant_id == id_t'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
   assign sel_a    = bus.req_a[grant_id*DATA_LEN +: DATA_LEN];
   assign sel_b    = bus.req_b[grant_id*DATA_LEN +: DATA_LEN];
   assign exit_tag = tag_pipe[MUL_LATENCY];
   assign deliver  = exit_tag.valid & ~flush;

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mul_reset   <= 1'b1;
         mul_a       <= '0;
         mul_b       <= '0;
         rr_ptr      <= '0;
         issue_count <= '0;
         for (int s = 0; s < DEPTH; s++) begin
            tag_pipe[s] <= '0;
         end
      end else begin
         mul_reset <= flush;
         if (issue) begin
            mul_a       <= sel_a;
            mul_b       <= sel_b;
            tag_pipe[0] <= '{valid: 1'b1, id: grant_id};
            rr_ptr      <= next_ptr;
            issue_count <= issue_count + 32'd1;
         end else begin
            mul_a       <= '0;
            mul_b       <= '0;
            tag_pipe[0] <= '0;
         end
         for (int s = 1; s < DEPTH; s++) begin
            tag_pipe[s] <= flush ? '0 : tag_pipe[s-1];
         end
      end
   end

   // NOTE: the result storage is reset too, so a reset leaves no stale product visible.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         inflight    <= '0;
         rsp_valid_q <= '0;
         for (int r = 0; r < NUM_REQ; r++) begin
            rsp_data[r] <= '0;
         end
      end else begin
         for (int r = 0; r < NUM_REQ; r++) begin
            if (flush) begin
               inflight[r] <= 1'b0;
            end else if (issue && grant_id == id_t'(r)) begin
               inflight[r] <= 1'b1;
            end else if (exit_tag.valid && exit_tag.id == id_t'(r)) begin
               inflight[r] <= 1'b0;
            end

            if (deliver && exit_tag.id == id_t'(r)) begin
               rsp_valid_q[r] <= 1'b1;
               rsp_data[r]    <= mul_result;
            end else if (rsp_valid_q[r] && bus.rsp_ready[r]) begin
               rsp_valid_q[r] <= 1'b0;
            end
         end
      end
   end

   for (genvar r = 0; r < NUM_REQ; r++) begin : g_rsp
      assign bus.rsp_result[r*DATA_LEN +: DATA_LEN] = rsp_data[r];
   end

   // Ready is masked during reset so a held req_valid cannot show a grant.
   assign bus.req_ready = grant & {NUM_REQ{reset_n}};
   assign bus.rsp_valid = rsp_valid_q;
   assign busy          = (|inflight) | (|rsp_valid_q);
endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter: a due-time queue model checked every
// cycle, plus literal expectations for the headline scenarios.
module tb_mul_share_arbiter;
   localparam int NR = 4;
   localparam int DL = 32;
   localparam int L  = 2;

   logic          clk     = 1'b0;
   logic          reset_n = 1'b0;
   logic          flush   = 1'b0;
   logic          mul_reset;
   logic [DL-1:0] mul_a;
   logic [DL-1:0] mul_b;
   logic [DL-1:0] mul_result;
   logic          busy;
   logic [31:0]   issue_count;

   int checks   = 0;
   int failures = 0;

   mul_share_arbiter_if #(.NUM_REQ(NR), .DATA_LEN(DL)) bus ();

   mul_share_arbiter #(.NUM_REQ(NR), .DATA_LEN(DL), .MUL_LATENCY(L)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .bus        (bus),
      .flush      (flush),
      .mul_reset  (mul_reset),
      .mul_a      (mul_a),
      .mul_b      (mul_b),
      .mul_result (mul_result),
      .busy       (busy),
      .issue_count(issue_count)
   );

   always #5 clk = ~clk;

   // Stand-in multiplier: product appears L clocks after the operands.
   logic [DL-1:0] mpipe [L];
   always @(posedge clk) begin
      if (mul_reset) begin
         for (int i = 0; i < L; i++) mpipe[i] <= '0;
      end else begin
         mpipe[0] <= mul_a * mul_b;
         for (int i = 1; i < L; i++) mpipe[i] <= mpipe[i-1];
      end
   end
   assign mul_result = mpipe[L-1];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      int            id;
      logic [DL-1:0] prod;
      int            due;
   } op_t;

   op_t           m_ops[$];
   logic [NR-1:0] m_inflight;
   logic [NR-1:0] m_rsp_valid;
   logic [DL-1:0] m_rsp_data [NR];
   int            m_rr;
   logic [31:0]   m_count;
   logic          m_mul_reset;
   logic [DL-1:0] m_mul_a;
   logic [DL-1:0] m_mul_b;
   int            cyc = 0;

   task automatic model_reset();
      m_ops.delete();
      m_inflight  = '0;
      m_rsp_valid = '0;
      for (int i = 0; i < NR; i++) m_rsp_data[i] = '0;
      m_rr        = 0;
      m_count     = '0;
      m_mul_reset = 1'b1;
      m_mul_a     = '0;
      m_mul_b     = '0;
   endtask

   function automatic int exp_grant();
      for (int off = 0; off < NR; off++) begin
         int i;
         i = (m_rr + off) % NR;
         if (bus.req_valid[i] && !m_inflight[i] && !m_rsp_valid[i] && !flush) return i;
      end
      return -1;
   endfunction

   task automatic model_step();
      int            g;
      op_t           keep[$];
      logic [DL-1:0] a;
      logic [DL-1:0] b;
      logic [DL-1:0] p;
      g = exp_grant();
      cyc++;
      for (int r = 0; r < NR; r++)
         if (m_rsp_valid[r] && bus.rsp_ready[r]) m_rsp_valid[r] = 1'b0;
      if (flush) begin
         m_ops.delete();
         m_inflight = '0;
      end else begin
         foreach (m_ops[j]) begin
            if (m_ops[j].due == cyc) begin
               m_rsp_valid[m_ops[j].id] = 1'b1;
               m_rsp_data[m_ops[j].id]  = m_ops[j].prod;
               m_inflight[m_ops[j].id]  = 1'b0;
            end else begin
               keep.push_back(m_ops[j]);
            end
         end
         m_ops = keep;
      end
      m_mul_reset = flush;
      if (g >= 0) begin
         a = bus.req_a[g*DL +: DL];
         b = bus.req_b[g*DL +: DL];
         p = a * b;
         m_ops.push_back('{id: g, prod: p, due: cyc + L + 1});
         m_inflight[g] = 1'b1;
         m_rr          = (g + 1) % NR;
         m_count       = m_count + 32'd1;
         m_mul_a       = a;
         m_mul_b       = b;
      end else begin
         m_mul_a = '0;
         m_mul_b = '0;
      end
   endtask

   always @(posedge clk) if (reset_n) model_step();
   always @(negedge reset_n) model_reset();

   // Compare process: every cycle, away from the active edge.
   always @(negedge clk) begin
      logic [NR-1:0] er;
      int            g;
      er = '0;
      g  = reset_n ? exp_grant() : -1;
      if (g >= 0) er[g] = 1'b1;
      check("req_ready", 64'(bus.req_ready), 64'(er));
      check("rsp_valid", 64'(bus.rsp_valid), 64'(m_rsp_valid));
      for (int r = 0; r < NR; r++)
         check($sformatf("rsp_result%0d", r), 64'(bus.rsp_result[r*DL +: DL]), 64'(m_rsp_data[r]));
      check("mul_a", 64'(mul_a), 64'(m_mul_a));
      check("mul_b", 64'(mul_b), 64'(m_mul_b));
      check("mul_reset", 64'(mul_reset), 64'(m_mul_reset));
      check("busy", 64'(busy), 64'(|m_inflight || |m_rsp_valid));
      check("issue_count", 64'(issue_count), 64'(m_count));
   end

   // ---------------- event log for literal checks ----------------
   typedef struct {
      int            id;
      int            edge_n;
      logic [DL-1:0] val;
   } ev_t;

   ev_t           grants[$];
   ev_t           rises[$];
   logic [NR-1:0] prev_rv = '0;

   always @(negedge clk) begin
      if (reset_n) begin
         for (int i = 0; i < NR; i++) begin
            if (bus.req_valid[i] && bus.req_ready[i]) grants.push_back('{id: i, edge_n: cyc + 1, val: '0});
            if (bus.rsp_valid[i] && !prev_rv[i])
               rises.push_back('{id: i, edge_n: cyc, val: bus.rsp_result[i*DL +: DL]});
         end
         prev_rv = bus.rsp_valid;
      end else begin
         prev_rv = '0;
      end
   end

   function automatic int count_ev(input ev_t q[$], input int id);
      int n = 0;
      foreach (q[j]) if (q[j].id == id) n++;
      return n;
   endfunction

   function automatic ev_t nth_ev(input ev_t q[$], input int id, input int n);
      int k = 0;
      foreach (q[j]) begin
         if (q[j].id == id) begin
            if (k == n) return q[j];
            k++;
         end
      end
      return '{id: -1, edge_n: -100, val: 'x};
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_req(input int i, input logic [DL-1:0] a, input logic [DL-1:0] b);
      bus.req_valid[i]       = 1'b1;
      bus.req_a[i*DL +: DL] = a;
      bus.req_b[i*DL +: DL] = b;
   endtask

   // Requesters drop valid after their handshake unless listed in hold.
   task automatic drive(input int n, input logic [NR-1:0] hold);
      logic [NR-1:0] hs;
      repeat (n) begin
         #1;
         hs = bus.req_valid & bus.req_ready & ~hold;
         tick();
         bus.req_valid = bus.req_valid & ~hs;
      end
   endtask

   task automatic do_reset();
      reset_n       = 1'b0;
      flush         = 1'b0;
      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.rsp_ready = '1;
      tick(2);
      reset_n = 1'b1;
      tick(1);
      grants.delete();
      rises.delete();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      ev_t g0;
      ev_t ev;
      int  exp2 [NR];
      exp2 = '{3, 6, 9, 12};
      model_reset();
      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.rsp_ready = '1;

      // 1) single op, latency and product
      do_reset();
      check("t1_reset_count", 64'(issue_count), 0);
      set_req(0, 7, 6);
      #1;
      check("t1_ready0", 64'(bus.req_ready), 64'(4'b0001));
      drive(8, '0);
      g0 = nth_ev(grants, 0, 0);
      ev = nth_ev(rises, 0, 0);
      check("t1_latency_edges", 64'(ev.edge_n - g0.edge_n), 64'(L + 1));
      check("t1_result", 64'(ev.val), 64'd42);
      check("t1_count", 64'(issue_count), 1);

      // 2) all four at once: back-to-back grants and results
      do_reset();
      for (int i = 0; i < NR; i++) set_req(i, DL'(i + 1), 3);
      drive(12, '0);
      g0 = nth_ev(grants, 0, 0);
      for (int i = 0; i < NR; i++) begin
         check($sformatf("t2_order%0d", i), 64'(grants.size() > i ? grants[i].id : -1), 64'(i));
         ev = nth_ev(grants, i, 0);
         check($sformatf("t2_grant_edge%0d", i), 64'(ev.edge_n - g0.edge_n), 64'(i));
         ev = nth_ev(rises, i, 0);
         check($sformatf("t2_result%0d", i), 64'(ev.val), 64'(exp2[i]));
         check($sformatf("t2_result_edge%0d", i), 64'(ev.edge_n - g0.edge_n), 64'(i + L + 1));
      end
      check("t2_count", 64'(issue_count), 4);

      // 3) unread response blocks requester 1 only
      do_reset();
      bus.rsp_ready = 4'b1101;
      for (int i = 0; i < NR; i++) set_req(i, DL'(i + 10), 2);
      drive(12, 4'hF);
      check("t3_single_grant1", 64'(count_ev(grants, 1)), 1);
      check("t3_others_issue", 64'(count_ev(grants, 0) >= 2), 1);
      bus.req_valid = 4'b0010;
      tick(4);
      #1;
      check("t3_blocked", 64'(bus.req_ready[1]), 0);
      bus.rsp_ready[1] = 1'b1;
      #1;
      check("t3_pop_cycle", 64'(bus.req_ready[1]), 0);
      tick();
      #1;
      check("t3_after_pop", 64'(bus.req_ready[1]), 1);
      drive(6, '0);
      check("t3_second_grant1", 64'(count_ev(grants, 1)), 2);
      check("t3_result1", 64'(nth_ev(rises, 1, 1).val), 64'd22);

      // 4) product truncated to DATA_LEN bits
      do_reset();
      set_req(3, 32'hFFFF_FFFF, 2);
      drive(8, '0);
      check("t4_overflow", 64'(nth_ev(rises, 3, 0).val), 64'hFFFF_FFFE);

      // 5) flush one cycle after issuing req2
      do_reset();
      set_req(2, 5, 5);
      drive(1, '0);
      flush = 1'b1;
      set_req(0, 1, 1);
      #1;
      check("t5_no_grant_in_flush", 64'(bus.req_ready), 0);
      tick();
      flush = 1'b0;
      #1;
      check("t5_mul_reset_high", 64'(mul_reset), 1);
      check("t5_busy_cleared", 64'(busy), 0);
      check("t5_ready_after", 64'(bus.req_ready), 64'(4'b0001));
      drive(1, '0);
      check("t5_mul_reset_low", 64'(mul_reset), 0);
      tick(6);
      check("t5_no_rsp2", 64'(count_ev(rises, 2)), 0);
      check("t5_req0", 64'(nth_ev(rises, 0, 0).val), 1);
      set_req(2, 2, 9);
      drive(8, '0);
      check("t5_result2", 64'(nth_ev(rises, 2, 0).val), 64'd18);
      check("t5_grants2", 64'(count_ev(grants, 2)), 2);

      // 6) async reset with three ops in flight
      do_reset();
      set_req(0, 3, 4);
      set_req(1, 5, 6);
      set_req(2, 7, 8);
      drive(3, '0);
      check("t6_busy_before", 64'(busy), 1);
      set_req(3, 1, 1);
      #2;
      reset_n = 1'b0;
      #1;
      check("t6_async_ready", 64'(bus.req_ready), 0);
      check("t6_async_rsp_valid", 64'(bus.rsp_valid), 0);
      check("t6_async_busy", 64'(busy), 0);
      check("t6_async_mul_a", 64'(mul_a), 0);
      check("t6_async_mul_b", 64'(mul_b), 0);
      check("t6_async_count", 64'(issue_count), 0);
      check("t6_async_mul_reset", 64'(mul_reset), 1);
      bus.req_valid = '0;
      tick(2);
      reset_n = 1'b1;
      #1;
      check("t6_mul_reset_hold", 64'(mul_reset), 1);
      tick();
      check("t6_mul_reset_release", 64'(mul_reset), 0);
      tick(6);
      check("t6_no_stale_rsp", 64'(rises.size()), 0);
      for (int i = 0; i < NR; i++) set_req(i, DL'(i + 2), 5);
      #1;
      check("t6_rr_restart", 64'(bus.req_ready), 64'(4'b0001));
      drive(10, '0);
      check("t6_count", 64'(issue_count), 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
